// File: rtl/wide_mult_pkg.sv
// Shared types and helpers for the time-shared wide multiplier sequencer.
package wide_mult_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DONE} wm_state_t;

  localparam int unsigned NUM_STEPS = 4;

  // Partial-product weight in units of WIDTH: lo*lo=0, hi*lo=1, lo*hi=1, hi*hi=2.
  function automatic logic [1:0] shift_of(input logic [1:0] step);
    return {1'b0, step[0]} + {1'b0, step[1]};
  endfunction

endpackage

// File: rtl/multiplier.sv
// Purely combinational WIDTH x WIDTH unsigned array multiplier.
module multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned OW = 2 * WIDTH;

  always_comb begin
    p = OW'(x) * OW'(y);
  end

endmodule

// File: rtl/wide_mult_ctrl.sv
// 2W x 2W unsigned multiply built from four passes through one W x W multiplier,
// with valid/ready handshakes on both the operand and the result side.
module wide_mult_ctrl
  import wide_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   a,
  input  logic [2*WIDTH-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int unsigned OW = 2 * WIDTH;
  localparam int unsigned RW = 4 * WIDTH;
  localparam logic [1:0]  LAST_STEP = 2'(NUM_STEPS - 1);

  wm_state_t         state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [OW-1:0]     a_q, a_d;
  logic [OW-1:0]     b_q, b_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  mul_x, mul_y;
  logic [OW-1:0]     pp;

  // Multiplier is fed only from the latched operands, never from the ports.
  always_comb begin
    mul_x = step_q[0] ? a_q[OW-1:WIDTH] : a_q[WIDTH-1:0];
    mul_y = step_q[1] ? b_q[OW-1:WIDTH] : b_q[WIDTH-1:0];
  end

  multiplier #(.WIDTH(WIDTH)) u_mult (
    .x (mul_x),
    .y (mul_y),
    .p (pp)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          step_d  = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + (RW'(pp) << (WIDTH * shift_of(step_q)));
        step_d = step_q + 2'd1;
        if (step_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next-state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;

endmodule

// File: tb/tb_wide_mult_ctrl.sv
// Scoreboard bench for wide_mult_ctrl: expected products queued at input handshake.
module tb_wide_mult_ctrl;

  localparam int unsigned WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_in_hs  = 0;
  int n_out_hs = 0;

  logic [31:0] exp_q[$];

  wide_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drives one operand pair until accepted; pushes the expected product on acceptance.
  // Returns at posedge+1.
  task automatic send(input logic [15:0] x, input logic [15:0] y, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    a = x;
    b = y;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        exp_q.push_back(32'(x) * 32'(y));
        n_in_hs++;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Counts edges after acceptance until out_valid is seen (sampled at posedge+1).
  task automatic wait_out(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h, required 1 0 0 00000000",
               in_ready, out_valid, busy, result);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string name, input logic [15:0] x, input logic [15:0] y);
    bit ok;
    int cyc;
    logic [31:0] exp;
    out_ready = 1'b1;
    send(x, y, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_accept: in_ready never high, required acceptance", name);
      return;
    end
    wait_out(cyc, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || cyc != 4) begin
      n_fail++;
      $display("FAIL %s_latency: edges=%0d seen=%b, required 4 edges", name, cyc, ok);
    end
    n_checks++;
    if (result !== exp) begin
      n_fail++;
      $display("FAIL %s_result: got %h, required %h", name, result, exp);
    end
    n_out_hs++;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_return_idle: out_valid=%b in_ready=%b, required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    run_one("basic", 16'h1234, 16'h5678);
    n_checks++;
    if (result !== 32'h06260060) begin
      n_fail++;
      $display("FAIL basic_const: got %h, required 06260060", result);
    end
  endtask

  task automatic test_max();
    run_one("max", 16'hFFFF, 16'hFFFF);
    n_checks++;
    if (result !== 32'hFFFE0001) begin
      n_fail++;
      $display("FAIL max_const: got %h, required fffe0001", result);
    end
  endtask

  task automatic test_zero_backpressure();
    bit ok;
    int cyc;
    logic [31:0] exp;
    out_ready = 1'b0;
    send(16'h0000, 16'hFFFF, ok);
    wait_out(cyc, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || cyc != 4 || result !== exp) begin
      n_fail++;
      $display("FAIL zero_result: edges=%0d seen=%b result=%h, required 4 1 %h", cyc, ok, result, exp);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || result !== exp || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: out_valid=%b result=%h in_ready=%b, required 1 %h 0",
                 i, out_valid, result, in_ready, exp);
      end
    end
    out_ready = 1'b1;
    n_out_hs++;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    int cyc;
    logic [31:0] exp;
    out_ready = 1'b1;
    send(16'hBEEF, 16'h1357, ok);
    in_valid = 1'b1;
    a = 16'h0001;
    b = 16'h0001;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_flags[%0d]: in_ready=%b busy=%b, required 0 1", i, in_ready, busy);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_out(cyc, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || cyc != 2 || result !== exp) begin
      n_fail++;
      $display("FAIL busy_result: edges=%0d seen=%b result=%h, required 2 1 %h", cyc, ok, result, exp);
    end
    n_out_hs++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_no_second[%0d]: out_valid=%b busy=%b, required 0 0", i, out_valid, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b1;
    send(16'h4321, 16'h8765, ok);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    n_in_hs--;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b result=%h, required 1 0 0 00000000",
               in_ready, out_valid, busy, result);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_discard[%0d]: out_valid=%b, required 0", i, out_valid);
      end
    end
    // Reset and in_valid on the same edge: the pair must be dropped.
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'h0007;
    b = 16'h0007;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_vs_valid: busy=%b in_ready=%b, required 0 1", busy, in_ready);
    end
    run_one("after_reset", 16'h0003, 16'h0005);
    n_checks++;
    if (result !== 32'h0000000F) begin
      n_fail++;
      $display("FAIL after_reset_const: got %h, required 0000000f", result);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit got;
    logic [31:0] exp;
    int base_in;
    int base_out;
    base_in = n_in_hs;
    base_out = n_out_hs;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(16'($urandom), 16'($urandom), ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_accept[%0d]: in_ready never high, required acceptance", n);
        break;
      end
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rand_extra[%0d]: output %h with empty scoreboard, required none", n, result);
          end else begin
            exp = exp_q.pop_front();
            if (result !== exp) begin
              n_fail++;
              $display("FAIL rand_result[%0d]: got %h, required %h", n, result, exp);
            end
          end
          n_out_hs++;
          got = 1'b1;
          @(posedge clk);
          #1;
          break;
        end
        @(posedge clk);
        #1;
      end
      if (!got) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_timeout[%0d]: no output handshake, required one", n);
        break;
      end
    end
    out_ready = 1'b1;
    n_checks++;
    if ((n_in_hs - base_in) != (n_out_hs - base_out) || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_balance: in=%0d out=%0d pending=%0d, required equal counts and 0 pending",
               n_in_hs - base_in, n_out_hs - base_out, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
